// File: rtl/common_cntdn3_pkg.sv
// common_cntdn3_pkg: shared constants and state encoding for the common_* counter blocks.
package common_cntdn3_pkg;

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } cnt_state_e;

endpackage

// File: rtl/common_rtlrom_decr3.sv
// common_rtlrom_decr3: 3-bit decrement as a case-table ROM; b flags the borrow out of zero.
module common_rtlrom_decr3 (
    input  logic [2:0] d,
    output logic [2:0] q,
    output logic       b
);
    logic [3:0] rom;

    always_comb begin
        case (d)
            3'd0:    rom = 4'b1_111;
            3'd1:    rom = 4'b0_000;
            3'd2:    rom = 4'b0_001;
            3'd3:    rom = 4'b0_010;
            3'd4:    rom = 4'b0_011;
            3'd5:    rom = 4'b0_100;
            3'd6:    rom = 4'b0_101;
            default: rom = 4'b0_110;
        endcase
    end

    assign b = rom[3];
    assign q = rom[2:0];
endmodule

// File: rtl/common_cntdn3.sv
// common_cntdn3: loadable 3-bit down-counter FSM with pause, abort and optional auto-reload.
module common_cntdn3
    import common_cntdn3_pkg::*;
#(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [CNT_W-1:0] start_value,
    input  logic             pause,
    input  logic             abort,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done
);
    cnt_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d, reload_q, reload_d, dec;
    logic             borrow, load;

    common_rtlrom_decr3 u_decr (.d(count_q), .q(dec), .b(borrow));

    assign start_ready = (state_q == ST_IDLE) & ~abort;
    assign load        = start_valid & start_ready;
    assign count       = count_q;
    assign busy        = state_q != ST_IDLE;
    assign done        = state_q == ST_DONE;

    // Abort outranks everything; a borrow ends the run at 0 instead of wrapping to 7.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        if (abort) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (load) begin
            state_d  = ST_RUN;
            count_d  = start_value;
            reload_d = start_value;
        end else if (state_q == ST_RUN && !pause) begin
            state_d = borrow ? ST_DONE : ST_RUN;
            count_d = borrow ? '0 : dec;
        end else if (state_q == ST_DONE) begin
            state_d = AUTO_RELOAD ? ST_RUN : ST_IDLE;
            count_d = AUTO_RELOAD ? reload_q : '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
        end
    end
endmodule
